// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sizes and scan FSM state type for the OAM scan loader.
// Rev 1.0
`default_nettype none

package sprite_pkg;
  localparam int NUM_SLOTS   = 10;
  localparam int NUM_ENTRIES = 40;
  localparam int IDX_W       = 6;
  localparam int ROW_W       = 4;
  localparam int Y_OFFSET    = 16;
  localparam int SPR_H_SHORT = 8;
  localparam int SPR_H_TALL  = 16;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scan_state_t;
endpackage

`default_nettype wire

// File: rtl/oam_scan_loader_if.sv
// oam_scan_loader_if: line control, OAM read port and sprite-store write port.
// Rev 1.0
`default_nettype none

interface oam_scan_loader_if;
  import sprite_pkg::*;

  logic                 line_start;
  logic [7:0]           ly;
  logic                 tall;
  logic                 oam_rd;
  logic [IDX_W-1:0]     oam_idx;
  logic [7:0]           oam_y;
  logic                 slot_clr;
  logic [NUM_SLOTS-1:0] store_en;
  logic [IDX_W-1:0]     store_idx;
  logic [ROW_W-1:0]     store_row;
  logic [3:0]           slot_count;
  logic                 scan_busy;
  logic                 scan_done;
  logic [5:0]           ovf_count;

  modport master (
    input  line_start, ly, tall, oam_y,
    output oam_rd, oam_idx, slot_clr, store_en, store_idx, store_row,
           slot_count, scan_busy, scan_done, ovf_count
  );

  modport slave (
    output line_start, ly, tall, oam_y,
    input  oam_rd, oam_idx, slot_clr, store_en, store_idx, store_row,
           slot_count, scan_busy, scan_done, ovf_count
  );
endinterface

`default_nettype wire

// File: rtl/sprite_y_match.sv
// sprite_y_match: decides whether an OAM Y byte covers the current line, and which sprite row.
// Rev 1.0
`default_nettype none

module sprite_y_match
  import sprite_pkg::*;
(
  input  logic [7:0]       ly,
  input  logic [7:0]       oam_y,
  input  logic             tall,
  output logic             match,
  output logic [ROW_W-1:0] row
);
  logic [7:0] diff;
  logic [7:0] height;

  // OAM Y is stored offset by 16, so wrap-around in 8 bits is intended
  assign diff   = ly + 8'(Y_OFFSET) - oam_y;
  assign height = tall ? 8'(SPR_H_TALL) : 8'(SPR_H_SHORT);
  assign match  = (diff < height);
  assign row    = diff[ROW_W-1:0];
endmodule

`default_nettype wire

// File: rtl/oam_scan_loader.sv
// oam_scan_loader: per-line scan of 40 OAM Y bytes, loading up to 10 matches into store slots.
// Option: define SCAN_OVERFLOW_EN to count dropped matches on ovf_count. Rev 1.0
`default_nettype none

module oam_scan_loader
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  oam_scan_loader_if.master bus
);
  scan_state_t          state;
  logic [7:0]           ly_q;
  logic                 tall_q;
  logic                 rd_d;
  logic [IDX_W-1:0]     idx_d;
  logic                 oam_rd;
  logic [IDX_W-1:0]     oam_idx;
  logic                 slot_clr;
  logic [NUM_SLOTS-1:0] store_en;
  logic [IDX_W-1:0]     store_idx;
  logic [ROW_W-1:0]     store_row;
  logic [3:0]           slot_count;
  logic                 scan_busy;
  logic                 scan_done;
  logic                 match;
  logic [ROW_W-1:0]     row;
  logic                 slots_full;

  sprite_y_match u_match (
    .ly    (ly_q),
    .oam_y (bus.oam_y),
    .tall  (tall_q),
    .match (match),
    .row   (row)
  );

  assign slots_full = (slot_count == 4'(NUM_SLOTS));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      ly_q       <= '0;
      tall_q     <= 1'b0;
      rd_d       <= 1'b0;
      idx_d      <= '0;
      oam_rd     <= 1'b0;
      oam_idx    <= '0;
      slot_clr   <= 1'b0;
      store_en   <= '0;
      store_idx  <= '0;
      store_row  <= '0;
      slot_count <= '0;
      scan_busy  <= 1'b0;
      scan_done  <= 1'b0;
    end else begin
      slot_clr  <= 1'b0;
      scan_done <= 1'b0;
      store_en  <= '0;
      store_idx <= '0;
      store_row <= '0;
      rd_d      <= oam_rd;
      idx_d     <= oam_idx;
      if (bus.line_start) begin
        // Restart from any state; the compare in flight this cycle is dropped
        state      <= SCAN;
        ly_q       <= bus.ly;
        tall_q     <= bus.tall;
        oam_rd     <= 1'b1;
        oam_idx    <= '0;
        slot_count <= '0;
        slot_clr   <= 1'b1;
        scan_busy  <= 1'b1;
        rd_d       <= 1'b0;
      end else begin
        if (rd_d && match && !slots_full) begin
          store_en   <= {{(NUM_SLOTS-1){1'b0}}, 1'b1} << slot_count;
          store_idx  <= idx_d;
          store_row  <= row;
          slot_count <= slot_count + 4'd1;
        end
        case (state)
          SCAN: begin
            if (oam_idx == IDX_W'(NUM_ENTRIES-1)) begin
              state   <= DRAIN;
              oam_rd  <= 1'b0;
              oam_idx <= '0;
            end else begin
              oam_idx <= oam_idx + 1'b1;
            end
          end
          DRAIN: begin
            state     <= DONE;
            scan_done <= 1'b1;
            scan_busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SCAN_OVERFLOW_EN
  logic [5:0] ovf_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ovf_q <= '0;
    end else if (bus.line_start) begin
      ovf_q <= '0;
    end else if (rd_d && match && slots_full && (ovf_q != 6'h3F)) begin
      ovf_q <= ovf_q + 6'd1;
    end
  end

  assign bus.ovf_count = ovf_q;
`else
  assign bus.ovf_count = '0;
`endif

  assign bus.oam_rd     = oam_rd;
  assign bus.oam_idx    = oam_idx;
  assign bus.slot_clr   = slot_clr;
  assign bus.store_en   = store_en;
  assign bus.store_idx  = store_idx;
  assign bus.store_row  = store_row;
  assign bus.slot_count = slot_count;
  assign bus.scan_busy  = scan_busy;
  assign bus.scan_done  = scan_done;
endmodule

`default_nettype wire

// File: tb/tb_oam_scan_loader.sv
// tb_oam_scan_loader: directed scanline scenarios with a queue-based strobe scoreboard.
// Rev 1.0
`default_nettype none

module tb_oam_scan_loader;
  logic clk;
  logic nreset;

  oam_scan_loader_if bus ();

  oam_scan_loader dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int slot;
    int idx;
    int row;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] mem [64];
  int         n_tests;
  int         n_fail;
  logic       oam_req;
  logic [5:0] oam_ridx;

  // OAM read port: Y byte appears the cycle after the request
  always @(posedge clk) begin
    oam_req  = bus.oam_rd;
    oam_ridx = bus.oam_idx;
    #1 bus.oam_y = oam_req ? mem[oam_ridx] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nreset) begin
      if (bus.store_en != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'(bus.store_en), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("store_en", 32'(bus.store_en), 32'd1 << mon_e.slot);
          check("store_idx", 32'(bus.store_idx), 32'(mon_e.idx));
          check("store_row", 32'(bus.store_row), 32'(mon_e.row));
        end
      end else begin
        check("idle_idx_row", {22'd0, bus.store_idx, bus.store_row}, 32'd0);
      end
    end
  end

  task automatic fill(input logic [7:0] y);
    for (int i = 0; i < 64; i++) mem[i] = y;
  endtask

  // Push expected strobes for entries 0..limit; return full-line slot and drop counts
  task automatic start(input logic [7:0] l, input logic t, input int limit,
                       output int cnt, output int ovf);
    logic [7:0] d;
    int         h;
    cnt = 0;
    ovf = 0;
    h   = t ? 16 : 8;
    for (int i = 0; i < 40; i++) begin
      d = l + 8'd16 - mem[i];
      if (int'(d) < h) begin
        if (cnt < 10) begin
          if (i <= limit) sb.push_back('{cnt, i, int'(d[3:0])});
          cnt++;
        end else begin
          ovf++;
        end
      end
    end
    if (ovf > 63) ovf = 63;
    @(negedge clk);
    bus.ly = l;
    bus.tall = t;
    bus.line_start = 1'b1;
    @(posedge clk);
    #1 bus.line_start = 1'b0;
    check("slot_clr", 32'(bus.slot_clr), 32'd1);
    check("first_rd", {31'd0, bus.oam_rd}, 32'd1);
    check("first_idx", 32'(bus.oam_idx), 32'd0);
    check("count_clr", 32'(bus.slot_count), 32'd0);
    check("no_strobe", 32'(bus.store_en), 32'd0);
  endtask

  task automatic finish(input int cnt, input int ovf);
    int n;
    n = 1;
    while (!bus.scan_done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("done_cycle", 32'(n), 32'd42);
    check("slot_count", 32'(bus.slot_count), 32'(cnt));
    check("busy_low", {31'd0, bus.scan_busy}, 32'd0);
`ifdef SCAN_OVERFLOW_EN
    check("ovf_count", 32'(bus.ovf_count), 32'(ovf));
`else
    check("ovf_count", 32'(bus.ovf_count), 32'd0);
`endif
    @(negedge clk);
    #1 check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int   cnt;
    int   ovf;
    logic seen_done;
    n_tests = 0;
    n_fail  = 0;
    nreset  = 1'b0;
    bus.line_start = 1'b0;
    bus.ly   = 8'd0;
    bus.tall = 1'b0;
    bus.oam_y = 8'd0;
    fill(8'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd", {31'd0, bus.oam_rd}, 32'd0);
    check("rst_store_en", 32'(bus.store_en), 32'd0);
    check("rst_count", 32'(bus.slot_count), 32'd0);
    check("rst_busy", {30'd0, bus.scan_busy, bus.scan_done}, 32'd0);
    check("rst_ovf", 32'(bus.ovf_count), 32'd0);
    @(negedge clk);
    nreset = 1'b1;

    // Single match at entry 5
    fill(8'd0);
    mem[5] = 8'd16;
    start(8'd0, 1'b0, 39, cnt, ovf);
    check("t1_count", 32'(cnt), 32'd1);
    finish(cnt, ovf);

    // Tall sprites, two matches at row 6
    fill(8'd0);
    mem[3] = 8'd30;
    mem[7] = 8'd30;
    start(8'd20, 1'b1, 39, cnt, ovf);
    finish(cnt, ovf);

    // Every entry matches: 10 loads, 30 dropped
    fill(8'd116);
    start(8'd100, 1'b0, 39, cnt, ovf);
    check("t3_ovf_model", 32'(ovf), 32'd30);
    finish(cnt, ovf);

    // Row 8 only exists for tall sprites
    fill(8'd0);
    mem[9] = 8'd58;
    start(8'd50, 1'b0, 39, cnt, ovf);
    finish(cnt, ovf);
    start(8'd50, 1'b1, 39, cnt, ovf);
    finish(cnt, ovf);

    // Restart mid-scan: idx12 strobe would land on the restart edge
    fill(8'd0);
    mem[2]  = 8'd76;
    mem[12] = 8'd76;
    mem[13] = 8'd76;
    mem[20] = 8'd76;
    start(8'd60, 1'b0, 11, cnt, ovf);
    repeat (13) @(posedge clk);
    start(8'd60, 1'b0, 39, cnt, ovf);
    finish(cnt, ovf);

    // Asynchronous reset mid-scan
    fill(8'd0);
    mem[1]  = 8'd40;
    mem[30] = 8'd40;
    start(8'd30, 1'b1, 17, cnt, ovf);
    repeat (19) @(posedge clk);
    #1 nreset = 1'b0;
    #1;
    check("arst_rd", {31'd0, bus.oam_rd}, 32'd0);
    check("arst_idx", 32'(bus.oam_idx), 32'd0);
    check("arst_count", 32'(bus.slot_count), 32'd0);
    check("arst_busy", {31'd0, bus.scan_busy}, 32'd0);
    check("arst_sb", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    seen_done = 1'b0;
    repeat (45) begin
      @(posedge clk);
      #1 seen_done = seen_done | bus.scan_done | bus.scan_busy | bus.oam_rd;
    end
    check("post_rst_idle", {31'd0, seen_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
